// File: rtl/wpm_bcd_encoder.sv
// rtl/wpm_bcd_encoder.sv - Binary WPM x100 to packed BCD (3 integer + 2 decimal digits)
// Sequential double dabble, one operand bit per clock, start/done handshake.
module wpm_bcd_encoder #(
  parameter int IN_W    = 17,
  parameter int SAT_VAL = 99999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] wpm_x100,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [11:0]     wpm_integer,
  output logic [7:0]      wpm_decimal
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [IN_W-1:0]  SAT      = IN_W'(SAT_VAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [IN_W-1:0]  operand;
  logic [19:0]      bcd;
  logic [19:0]      bcd_adj;
  logic [19+IN_W:0] shifted;
  logic [CNT_W-1:0] cnt;
  logic             ovf_latch;

  // Add-3 correction on every nibble before the shift keeps each digit in 0..9.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, operand} << 1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      operand     <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf_latch   <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      wpm_integer <= 12'h000;
      wpm_decimal <= 8'h00;
    end else begin
      state <= state_next;
      done  <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            operand   <= (wpm_x100 > SAT) ? SAT : wpm_x100;
            ovf_latch <= (wpm_x100 > SAT);
            bcd       <= '0;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          bcd     <= shifted[19+IN_W:IN_W];
          operand <= shifted[IN_W-1:0];
          cnt     <= cnt + 1'b1;
        end
        FINISH: begin
          wpm_integer <= bcd[19:8];
          wpm_decimal <= bcd[7:0];
          overflow    <= ovf_latch;
        end
        default: ;
      endcase
    end
  end

  // The first SHIFT cycle is still the acceptance cycle; busy covers the IN_W cycles before done.
  assign busy = ((state == SHIFT) && (cnt != '0)) || (state == FINISH);

endmodule

// File: tb/tb_wpm_bcd_encoder.sv
// tb/tb_wpm_bcd_encoder.sv - Self-checking bench for wpm_bcd_encoder
// Countdown/arithmetic reference model compared every cycle, plus directed literal checks.
module tb_wpm_bcd_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] wpm_x100;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [11:0] wpm_integer;
  logic [7:0]  wpm_decimal;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  wpm_bcd_encoder dut (
    .clk(clk), .rst(rst), .start(start), .wpm_x100(wpm_x100),
    .busy(busy), .done(done), .overflow(overflow),
    .wpm_integer(wpm_integer), .wpm_decimal(wpm_decimal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a cycle countdown from acceptance to done, results by division.
  int          m_cnt = 0;
  int          m_op  = 0;
  logic [11:0] m_int = '0;
  logic [7:0]  m_dec = '0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;

  always @(posedge clk) begin
    int v;
    m_done = 1'b0;
    if (rst) begin
      m_cnt = 0; m_int = '0; m_dec = '0; m_ovf = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt = 18;
        m_op  = int'(wpm_x100);
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        v     = (m_op > 99999) ? 99999 : m_op;
        m_ovf = (m_op > 99999);
        m_int = {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10)};
        m_dec = {4'((v / 10) % 10), 4'(v % 10)};
        m_done = 1'b1;
      end
    end
    m_busy = (m_cnt >= 1) && (m_cnt <= 17);
  end

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (checking) begin
      chk("done", done, m_done);
      chk("busy", busy, m_busy);
      chk("overflow", overflow, m_ovf);
      chk("wpm_integer", wpm_integer, m_int);
      chk("wpm_decimal", wpm_decimal, m_dec);
      for (int i = 0; i < 3; i++)
        chk("int_nibble_le9", (wpm_integer[4*i +: 4] <= 4'd9), 1);
      for (int i = 0; i < 2; i++)
        chk("dec_nibble_le9", (wpm_decimal[4*i +: 4] <= 4'd9), 1);
      chk("done_width", (done && prev_done), 0);
      prev_done = done;
    end
  end

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic conv(input logic [16:0] x, output int cycles, output int busy_cycles);
    start = 1'b1;
    wpm_x100 = x;
    @(negedge clk);
    start = 1'b0;
    wait_done(cycles, busy_cycles);
  endtask

  initial begin
    int n, b;
    rst = 1'b1; start = 1'b0; wpm_x100 = '0;
    @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_int", wpm_integer, 12'h000);
    chk("reset_dec", wpm_decimal, 8'h00);

    // 1: zero input
    conv(17'd0, n, b);
    chk("t1_latency", n, 18);
    chk("t1_int", wpm_integer, 12'h000);
    chk("t1_dec", wpm_decimal, 8'h00);
    chk("t1_ovf", overflow, 0);
    @(negedge clk);

    // 2: typical value, busy width
    conv(17'd12345, n, b);
    chk("t2_int", wpm_integer, 12'h123);
    chk("t2_dec", wpm_decimal, 8'h45);
    chk("t2_busy_cycles", b, 17);
    @(negedge clk);

    // 3: saturation boundary and overflow
    conv(17'd99999, n, b);
    chk("t3a_int", wpm_integer, 12'h999);
    chk("t3a_dec", wpm_decimal, 8'h99);
    chk("t3a_ovf", overflow, 0);
    @(negedge clk);
    conv(17'd131071, n, b);
    chk("t3b_int", wpm_integer, 12'h999);
    chk("t3b_dec", wpm_decimal, 8'h99);
    chk("t3b_ovf", overflow, 1);
    @(negedge clk);

    // 4: start held high, back-to-back
    start = 1'b1;
    wpm_x100 = 17'd4560;
    wait_done(n, b);
    chk("t4a_int", wpm_integer, 12'h045);
    chk("t4a_dec", wpm_decimal, 8'h60);
    wpm_x100 = 17'd700;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, b);
    chk("t4_done_to_done", n + 1, 19);
    chk("t4b_int", wpm_integer, 12'h007);
    chk("t4b_dec", wpm_decimal, 8'h00);
    @(negedge clk);

    // 5: start and input changes mid-conversion are ignored
    start = 1'b1;
    wpm_x100 = 17'd12345;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    wpm_x100 = 17'd55555;
    @(negedge clk);
    start = 1'b0;
    wpm_x100 = 17'd1;
    wait_done(n, b);
    chk("t5_int", wpm_integer, 12'h123);
    chk("t5_dec", wpm_decimal, 8'h45);
    @(negedge clk);

    // 6: reset aborts a conversion
    start = 1'b1;
    wpm_x100 = 17'd12345;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (25) begin
      if (done) n++;
      @(negedge clk);
    end
    chk("t6_no_done", n, 0);
    chk("t6_busy", busy, 0);
    chk("t6_int", wpm_integer, 12'h000);
    chk("t6_dec", wpm_decimal, 8'h00);
    conv(17'd250, n, b);
    chk("t6_int_after", wpm_integer, 12'h002);
    chk("t6_dec_after", wpm_decimal, 8'h50);
    repeat (3) @(negedge clk);

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
